md_unit_ctrl: RTL and testbench

//  Multiply/divide sequencer for the E stage of the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO,

---
 rtl/md_pkg.sv | 37 +++
 rtl/md_unit_ctrl_if.sv | 28 ++
 rtl/md_arith.sv | 52 +++++
 rtl/md_unit_ctrl.sv | 130 +++++++++++++
 tb/tb_md_unit_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, result-mux
// selects, controller states, default latencies and op classification helpers.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_HI  = 2'b01,
        SEL_LO  = 2'b10
    } md_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
    localparam int MD_CNT_W       = 4;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// E-stage <-> multiply/divide unit signal bundle. The pipeline (master) issues
// ops and reads HI/LO; the unit (slave) returns busy, stall and the result select.
interface md_unit_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_hi;
    logic        rd_lo;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [1:0]  res_sel;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, rd_hi, rd_lo, d_md_use,
        input  busy, stall, res_sel, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, rd_hi, rd_lo, d_md_use,
        output busy, stall, res_sel, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: op/rs/rt -> 64-bit {hi, lo} result.
// DIV yields lo=quotient, hi=remainder (truncation toward zero).
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'b0, rs} * {32'b0, rt};

    assign rs_s   = rs;
    assign rt_s   = rt;
    assign quot_s = rs_s / rt_s;
    assign rem_s  = rs_s % rt_s;
    assign quot_u = rs / rt;
    assign rem_u  = rs % rt;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            MD_DIVU: begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed latency with a
// busy countdown, raises D-stage stalls and drives the E result-mux select.
// Optional: define MD_DIV0_GUARD_EN to keep HI/LO unchanged when a DIV/DIVU has rt==0.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = MD_CNT_W
) (
    input  logic           clk,
    input  logic           reset_n,
    md_unit_ctrl_if.slave  md
);

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] arith_hi;
    logic [31:0] arith_lo;
    logic        issue_muldiv;
    logic        commit_en;

    md_arith u_arith (
        .op     (md.op),
        .rs     (md.rs_data),
        .rt     (md.rt_data),
        .res_hi (arith_hi),
        .res_lo (arith_lo)
    );

    assign issue_muldiv = (state_q == ST_IDLE) && md.start && is_muldiv(md.op);

`ifdef MD_DIV0_GUARD_EN
    logic skip_q, skip_d;

    always_comb begin
        skip_d = skip_q;
        if (issue_muldiv) begin
            skip_d = is_div(md.op) && (md.rt_data == 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end

    assign commit_en = !skip_q;
`else
    assign commit_en = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (issue_muldiv) begin
                    state_d   = ST_BUSY;
                    cnt_d     = is_div(md.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    pend_hi_d = arith_hi;
                    pend_lo_d = arith_lo;
                end else if (md.start && (md.op == MD_MTHI)) begin
                    hi_d = md.rs_data;
                end else if (md.start && (md.op == MD_MTLO)) begin
                    lo_d = md.rs_data;
                end
            end
            ST_BUSY: begin
                // Any start seen here is dropped; the stall keeps a well-behaved pipeline from issuing.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (commit_en) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: HI/LO and the pending result are cleared on reset so an aborted op can never commit.
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    always_comb begin
        if (md.rd_hi) begin
            md.res_sel = SEL_HI;
        end else if (md.rd_lo) begin
            md.res_sel = SEL_LO;
        end else begin
            md.res_sel = SEL_ALU;
        end
    end

    assign md.busy  = (state_q == ST_BUSY);
    assign md.stall = md.d_md_use && (md.busy || (md.start && is_muldiv(md.op)));
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: a cycle-indexed reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_md_unit_ctrl;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    md_unit_ctrl_if bus ();

    md_unit_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference model: cyc counts rising edges; busy holds while cyc < busy_until.
    int          cyc = 0;
    int          busy_until = 0;
    bit          model_live = 0;
    bit          was_busy;
    bit          pending = 0;
    bit          pend_keep;
    bit          pend_unknown;
    bit          hi_unknown = 0;
    bit          lo_unknown = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi, p_lo;
    int          si, ti;
    longint      sa, sb, sp;
    logic [63:0] ua, ub, up;

    initial forever begin
        @(posedge clk);
        was_busy = (cyc < busy_until);
        cyc++;
        model_live = 1;
        if (!reset_n) begin
            m_hi = '0;
            m_lo = '0;
            pending = 0;
            busy_until = 0;
            hi_unknown = 0;
            lo_unknown = 0;
        end else begin
            if (pending && cyc == busy_until) begin
                pending = 0;
                if (pend_unknown) begin
                    hi_unknown = 1;
                    lo_unknown = 1;
                end else if (!pend_keep) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    hi_unknown = 0;
                    lo_unknown = 0;
                end
            end
            if (!was_busy && bus.start) begin
                pend_keep = 0;
                pend_unknown = 0;
                si = bus.rs_data;
                ti = bus.rt_data;
                case (bus.op)
                    3'd0: begin
                        sa = si;
                        sb = ti;
                        sp = sa * sb;
                        {p_hi, p_lo} = sp;
                    end
                    3'd1: begin
                        ua = {32'b0, bus.rs_data};
                        ub = {32'b0, bus.rt_data};
                        up = ua * ub;
                        {p_hi, p_lo} = up;
                    end
                    3'd2, 3'd3: begin
                        if (bus.rt_data == 32'd0) begin
`ifdef MD_DIV0_GUARD_EN
                            pend_keep = 1;
`else
                            pend_unknown = 1;
`endif
                        end else if (bus.op == 3'd2) begin
                            p_lo = si / ti;
                            p_hi = si % ti;
                        end else begin
                            p_lo = bus.rs_data / bus.rt_data;
                            p_hi = bus.rs_data % bus.rt_data;
                        end
                    end
                    default: ;
                endcase
                if (bus.op inside {3'd0, 3'd1}) begin
                    pending = 1;
                    busy_until = cyc + MULT_N;
                end else if (bus.op inside {3'd2, 3'd3}) begin
                    pending = 1;
                    busy_until = cyc + DIV_N;
                end else if (bus.op == 3'd4) begin
                    m_hi = bus.rs_data;
                    hi_unknown = 0;
                end else if (bus.op == 3'd5) begin
                    m_lo = bus.rs_data;
                    lo_unknown = 0;
                end
            end
        end
    end

    logic       exp_busy;
    logic       exp_stall;
    logic [1:0] exp_sel;

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            exp_busy  = (cyc < busy_until);
            exp_stall = bus.d_md_use && (exp_busy || (bus.start && bus.op < 3'd4));
            exp_sel   = bus.rd_hi ? 2'b01 : (bus.rd_lo ? 2'b10 : 2'b00);
            check("m_busy", 32'(bus.busy), 32'(exp_busy));
            check("m_stall", 32'(bus.stall), 32'(exp_stall));
            check("m_res_sel", 32'(bus.res_sel), 32'(exp_sel));
            if (!hi_unknown) check("m_hi", bus.hi, m_hi);
            if (!lo_unknown) check("m_lo", bus.lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = rs;
        bus.rt_data = rt;
        tick();
        bus.start   = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;  bus.op = 3'd0;  bus.rs_data = '0;  bus.rt_data = '0;
        bus.rd_hi = 1'b0;  bus.rd_lo = 1'b0;  bus.d_md_use = 1'b0;
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);

        // MULT / MULTU of -2 * 3
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy_first", 32'(bus.busy), 32'd1);
        repeat (MULT_N - 1) tick();
        check("mult_busy_last", 32'(bus.busy), 32'd1);
        tick();
        check("mult_busy_drop", 32'(bus.busy), 32'd0);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        repeat (MULT_N) tick();
        check("multu_hi", bus.hi, 32'h0000_0002);
        check("multu_lo", bus.lo, 32'hFFFF_FFFA);

        // DIV -7/2 with an MTHI attempted mid-flight, then DIVU 7/2
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(MD_MTHI, 32'h0000_DEAD, 32'd0);
        repeat (DIV_N - 2) tick();
        check("div_busy_last", 32'(bus.busy), 32'd1);
        tick();
        check("div_busy_drop", 32'(bus.busy), 32'd0);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        issue(MD_DIVU, 32'd7, 32'd2);
        repeat (DIV_N) tick();
        check("divu_lo", bus.lo, 32'd3);
        check("divu_hi", bus.hi, 32'd1);

        // MULT with an MD op waiting in D: stall across issue and busy cycles
        bus.d_md_use = 1'b1;
        bus.start = 1'b1;  bus.op = MD_MULT;  bus.rs_data = 32'd6;  bus.rt_data = 32'd7;
        #1;
        check("stall_issue", 32'(bus.stall), 32'd1);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < MULT_N; i++) begin
            check("stall_busy", 32'(bus.stall), 32'd1);
            tick();
        end
        check("stall_after", 32'(bus.stall), 32'd0);
        bus.d_md_use = 1'b0;
        bus.rd_lo = 1'b1;
        #1;
        check("mflo_sel", 32'(bus.res_sel), 32'd2);
        check("mflo_lo", bus.lo, 32'd42);
        tick();
        bus.rd_lo = 1'b0;

        // MTHI then MFHI, both read flags, reserved op
        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_hi", bus.hi, 32'h0000_1234);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        bus.rd_hi = 1'b1;
        #1;
        check("mfhi_sel", 32'(bus.res_sel), 32'd1);
        bus.rd_lo = 1'b1;
        #1;
        check("both_sel", 32'(bus.res_sel), 32'd1);
        tick();
        bus.rd_hi = 1'b0;  bus.rd_lo = 1'b0;
        issue(3'b110, 32'h0000_BEEF, 32'd1);
        check("rsvd_hi", bus.hi, 32'h0000_1234);
        check("rsvd_busy", 32'(bus.busy), 32'd0);

        // Reset during busy cycle 4 aborts the DIV
        issue(MD_MTLO, 32'h0000_0077, 32'd0);
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        repeat (DIV_N + 2) tick();
        check("abort_late_hi", bus.hi, 32'd0);
        check("abort_late_lo", bus.lo, 32'd0);

        // Divide by zero with HI/LO preloaded, MULT attempted while busy
        issue(MD_MTHI, 32'h0000_0055, 32'd0);
        issue(MD_MTLO, 32'h0000_0055, 32'd0);
        issue(MD_DIV, 32'd9, 32'd0);
        issue(MD_MULT, 32'd2, 32'd3);
        repeat (DIV_N - 2) tick();
        check("div0_busy_last", 32'(bus.busy), 32'd1);
        tick();
        check("div0_busy_drop", 32'(bus.busy), 32'd0);
`ifdef MD_DIV0_GUARD_EN
        check("div0_hi", bus.hi, 32'h0000_0055);
        check("div0_lo", bus.lo, 32'h0000_0055);
`endif
        tick();
        check("ignored_start_busy", 32'(bus.busy), 32'd0);
        issue(MD_MTHI, 32'h0000_00AA, 32'd0);
        issue(MD_MTLO, 32'h0000_00BB, 32'd0);
        check("restore_hi", bus.hi, 32'h0000_00AA);
        check("restore_lo", bus.lo, 32'h0000_00BB);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
